wallace_mul_pipe: RTL and testbench
===================================

Name: wallace_mul_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier for the core's M-extension datapath.
- Takes two WIDTH-bit operands with per-operand signedness and returns the full 2*WIDTH-bit product.
- Uses a valid/ready handshake, supports backpressure, and has a configurable pipeline depth.
- Structure: AND-array partial products, then a 3:2 CSA reduction tree, then a final carry-propagate add.
- Sits between the decode/issue stage and the writeback mux. The issue side selects MUL, MULH, MULHSU or MULHU by choosing the output half and the signed flags.

Parameters:
- WIDTH, 32: operand width; legal range 8..64, even values only.
- PIPE_STAGES, 3: register stages from input accept to output valid; legal range 1..4.
- TAG_W, 5: width of the sideband tag carried alongside each operation (destination register id).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- a_signed  input  1  1 = a is two's complement; 0 = a is unsigned.
- b_signed  input  1  1 = b is two's complement; 0 = b is unsigned.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- product  output  2*WIDTH  full product.
- out_tag  output  TAG_W  tag associated with product.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - While rst is high, every stage valid bit is cleared, so out_valid=0.
  - product=0 and out_tag=0 during reset.
  - in_ready=1 once rst deasserts.
- Arithmetic:
  - Each operand is extended to WIDTH+1 bits: sign-extended if its signed flag is set, otherwise zero-extended.
  - The result is the low 2*WIDTH bits of the (WIDTH+1)x(WIDTH+1) two's-complement product.
  - Baugh-Wooley correction terms are an acceptable alternative, provided results are bit-identical.
  - No overflow or saturation; the result is exact for all four sign combinations.
- Structure:
  - Stage boundaries: first register after partial-product generation, last register after the final add.
  - Remaining registers are spread evenly across the CSA reduction levels.
  - Each stage holds its own valid bit, its tag, and its redundant (sum, carry) vectors.
  - With PIPE_STAGES=1, the whole datapath is combinational into a single output register.
- Handshake (global-stall pipeline):
  - advance = !out_valid | out_ready, and in_ready = advance.
  - When advance=1, all stages shift one step. A beat is accepted when in_valid & in_ready.
  - When advance=0, all stage registers hold, and product/out_tag stay stable while out_valid=1.
  - Bubbles are not compressed.
- Latency and throughput:
  - Latency is exactly PIPE_STAGES cycles from the accept edge to the out_valid=1 edge, when there is no stall.
  - Throughput is 1 result per cycle while out_ready=1.
- Ordering: results leave in strict acceptance order, and each tag stays paired with its own operands.
- Simultaneous events: output handshake and input accept in the same cycle are legal, and no beat is lost or duplicated.
- in_valid low:
  - A bubble enters the pipeline, and its stage valid bit is 0.
  - Data registers of invalid stages are don't-care, but must not X-propagate into out_valid.
- Reset mid-operation: all in-flight beats are discarded, with no partial output afterwards. The first beat accepted after reset emerges after PIPE_STAGES cycles.
- Stable inputs: a, b, the signed flags and in_tag are sampled only on the accept edge. Changes while in_ready=0 have no effect.

Decomposition:
- Shared package mul_pkg holds:
  - mode encodings MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU, mapping to (a_signed, b_signed, take-high);
  - the localparam function computing the number of CSA levels for a given row count;
  - the default WIDTH, PIPE_STAGES and TAG_W.
- One natural sub-module, csa_row: a parametrised-width 3:2 compressor row (sum = x^y^z, carry = majority shifted left by 1).
  - It is instantiated per reduction node through a generate loop.
- The final adder is inline, written as a behavioural "+" on the last (sum, carry) pair.

Test Plan:
- WIDTH=32, PIPE_STAGES=3, unsigned, a=b=0xFFFFFFFF, tag=7
  -> product=0xFFFFFFFE00000001, out_tag=7, out_valid high exactly 3 cycles after accept.
- Both signed, a=b=0xFFFFFFFF -> product=0x0000000000000001.
- Both signed, a=b=0x80000000 -> product=0x4000000000000000.
- a signed / b unsigned, a=b=0xFFFFFFFF -> product=0xFFFFFFFF00000001.
- Backpressure:
  - Stimulus: stream 10 random beats back-to-back with tags 0..9, holding out_ready=0 for cycles 4..7.
  - Required: in_ready=0 during the stall; product/out_tag held stable; all 10 results in tag order and matching the reference model; no loss or duplicate.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 immediately (asynchronous), none of the 3 beats ever emerge; the next beat (5*7, tag 2) gives product=35 after 3 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the M-extension multiplier datapath: operation
// mode encodings, default parameters and the elaboration-time helpers that
// size and place registers in the CSA reduction tree.
package mul_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_PIPE_STAGES = 3;
    localparam int DEF_TAG_W       = 5;

    // Issue-side operation selector.
    typedef enum logic [1:0] {
        MUL_LO  = 2'd0,   // low half; signedness does not affect it
        MUL_HSS = 2'd1,   // high half, signed x signed
        MUL_HSU = 2'd2,   // high half, signed x unsigned
        MUL_HUU = 2'd3    // high half, unsigned x unsigned
    } mul_mode_e;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
        logic take_high;
    } mul_ctrl_t;

    // Map a mode onto the operand signed flags and the output half to use.
    function automatic mul_ctrl_t mode_ctrl(mul_mode_e mode);
        mul_ctrl_t ctrl;
        case (mode)
            MUL_LO:  ctrl = '{a_signed: 1'b1, b_signed: 1'b1, take_high: 1'b0};
            MUL_HSS: ctrl = '{a_signed: 1'b1, b_signed: 1'b1, take_high: 1'b1};
            MUL_HSU: ctrl = '{a_signed: 1'b1, b_signed: 1'b0, take_high: 1'b1};
            MUL_HUU: ctrl = '{a_signed: 1'b0, b_signed: 1'b0, take_high: 1'b1};
            default: ctrl = '{a_signed: 1'b0, b_signed: 1'b0, take_high: 1'b0};
        endcase
        return ctrl;
    endfunction

    // Rows remaining after 'lvl' levels of 3:2 compression (each full group
    // of three rows becomes two; leftovers pass through).
    function automatic int rows_at(int rows, int lvl);
        int n;
        n = rows;
        for (int i = 0; i < lvl; i++) begin
            n = n - (n / 3);
        end
        return n;
    endfunction

    // Number of CSA levels needed to bring 'rows' rows down to two.
    function automatic int csa_levels(int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = n - (n / 3);
            l = l + 1;
        end
        return l;
    endfunction

    // Whether the row set entering CSA level 'bnd' is registered. Boundary 0
    // sits right after partial-product generation; the remaining interior
    // registers are spread evenly over the tree levels. The output register
    // after the final add is always present and is not counted here.
    function automatic bit boundary_reg(int bnd, int levels, int stages);
        bit r;
        r = 1'b0;
        if (bnd == 0) begin
            r = (stages >= 2);
        end else begin
            for (int m = 1; m <= stages - 2; m++) begin
                if (((levels * m) / (stages - 1)) == bnd) begin
                    r = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wallace_mul_pipe_csa_row.sv
// One row of 3:2 carry-save compressors across a W-bit vector. The carry
// output is already shifted into its weight position; the majority bit out
// of the top column falls outside the product width and is dropped.
module csa_row #(
    parameter int W = 64
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    assign sum_o   = x_i ^ y_i ^ z_i;
    assign carry_o = {(x_i[W-2:0] & y_i[W-2:0]) |
                      (x_i[W-2:0] & z_i[W-2:0]) |
                      (y_i[W-2:0] & z_i[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace-tree multiplier with per-operand signedness, a sideband
// tag and a global-stall valid/ready handshake.
//
// Each operand is treated as a WIDTH+1 bit two's-complement number. The
// multiplier rows for bits 0..WIDTH-1 are plain AND rows of the
// sign-extended multiplicand; the row for the extension bit carries negative
// weight and is added as its one's complement plus a separate +1 row.
// All rows are reduced by 3:2 compressors to a (sum, carry) pair and a
// single behavioural add produces the product.
module wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES,
    parameter int TAG_W       = DEF_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int P    = 2 * WIDTH;         // product width
    localparam int ROWS = WIDTH + 2;         // WIDTH+1 multiplier rows plus the +1 row
    localparam int LVLS = csa_levels(ROWS);

    logic             advance_s;
    logic [P-1:0]     a_ext_s;
    logic             b_top_s;
    logic [P-1:0]     pp_s [ROWS];
    logic [P-1:0]     product_d;

    logic             out_valid_q;
    logic [P-1:0]     product_q;
    logic [TAG_W-1:0] out_tag_q;

    // Every stage moves together; a full output register that is not being
    // drained freezes the whole pipe.
    assign advance_s = !out_valid_q | out_ready;
    assign in_ready  = advance_s;

    assign a_ext_s = {{WIDTH{a_signed & a[WIDTH-1]}}, a};
    assign b_top_s = b_signed & b[WIDTH-1];

    // Partial-product array: AND rows, the negative-weight top row as its
    // complement, and the +1 that completes the negation.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_s[i] = {P{b[i]}} & (a_ext_s << i);
        end
        pp_s[WIDTH]   = {P{b_top_s}} & ~(a_ext_s << WIDTH);
        pp_s[WIDTH+1] = {{(P-1){1'b0}}, b_top_s};
    end

    // Boundary k holds the rows entering CSA level k (k == LVLS is the final
    // sum/carry pair). lvl_d is the combinational row set; lvl_q is either a
    // register of it or a direct alias when this boundary is not a stage.
    for (genvar k = 0; k <= LVLS; k++) begin : g_bnd
        localparam int CNT    = rows_at(ROWS, k);
        localparam bit IS_REG = boundary_reg(k, LVLS, PIPE_STAGES);

        logic [P-1:0]     lvl_d [CNT];
        logic [P-1:0]     lvl_q [CNT];
        logic             v_d;
        logic             v_q;
        logic [TAG_W-1:0] tag_d;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_src
            assign lvl_d = pp_s;
            assign v_d   = in_valid;
            assign tag_d = in_tag;
        end else begin : g_red
            localparam int PREV = rows_at(ROWS, k - 1);
            localparam int GRP  = PREV / 3;

            for (genvar j = 0; j < GRP; j++) begin : g_csa
                csa_row #(
                    .W (P)
                ) u_csa (
                    .x_i     (g_bnd[k-1].lvl_q[3*j]),
                    .y_i     (g_bnd[k-1].lvl_q[3*j+1]),
                    .z_i     (g_bnd[k-1].lvl_q[3*j+2]),
                    .sum_o   (lvl_d[2*j]),
                    .carry_o (lvl_d[2*j+1])
                );
            end

            for (genvar m = 0; m < PREV - 3 * GRP; m++) begin : g_pass
                assign lvl_d[2*GRP+m] = g_bnd[k-1].lvl_q[3*GRP+m];
            end

            assign v_d   = g_bnd[k-1].v_q;
            assign tag_d = g_bnd[k-1].tag_q;
        end

        if (IS_REG) begin : g_reg
            // Stage valid bit: cleared by reset so bubbles never look valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (advance_s) begin
                    v_q <= v_d;
                end
            end

            // Stage payload: don't-care while invalid, so no reset needed.
            always_ff @(posedge clk) begin
                if (advance_s) begin
                    lvl_q <= lvl_d;
                    tag_q <= tag_d;
                end
            end
        end else begin : g_wire
            assign lvl_q = lvl_d;
            assign v_q   = v_d;
            assign tag_q = tag_d;
        end
    end

    // Final carry-propagate add of the reduced pair.
    always_comb begin
        product_d = g_bnd[LVLS].lvl_q[0] + g_bnd[LVLS].lvl_q[1];
    end

    // Output stage: product and tag are cleared by reset and hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
            out_tag_q   <= '0;
        end else if (advance_s) begin
            out_valid_q <= g_bnd[LVLS].v_q;
            product_q   <= product_d;
            out_tag_q   <= g_bnd[LVLS].tag_q;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Self-checking bench for wallace_mul_pipe (WIDTH=32, PIPE_STAGES=3):
// directed products and latency, backpressure, mid-stream reset and a
// randomized stream scored against a plain-arithmetic reference model.
module tb_wallace_mul_pipe;
    import mul_pkg::*;

    localparam int W  = 32;
    localparam int S  = 3;
    localparam int TW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            a_signed = 1'b0;
    logic            b_signed = 1'b0;
    logic [TW-1:0]   in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [2*W-1:0]  product;
    logic [TW-1:0]   out_tag;

    typedef struct {
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   acc_flag;

    always #5 clk = ~clk;

    wallace_mul_pipe #(
        .WIDTH       (W),
        .PIPE_STAGES (S),
        .TAG_W       (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: extend each operand per its flag, multiply exactly, keep low 2W bits.
    function automatic logic [63:0] ref_mul(logic [31:0] x, logic [31:0] y, logic xs, logic ys);
        logic signed [65:0] xe;
        logic signed [65:0] ye;
        logic signed [65:0] pr;
        xe = xs ? {{34{x[31]}}, x} : {34'd0, x};
        ye = ys ? {{34{y[31]}}, y} : {34'd0, y};
        pr = xe * ye;
        return pr[63:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // One clock: inputs already driven at the falling edge; observe, score, advance.
    task automatic cycle();
        #1;
        chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                chk("product", product, sb[0].p);
                chk("out_tag", {59'd0, out_tag}, {59'd0, sb[0].t});
                if (out_ready) sb.pop_front();
            end
        end
        acc_flag = in_valid && in_ready;
        if (acc_flag) sb.push_back('{ref_mul(a, b, a_signed, b_signed), in_tag});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_now();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", {63'd0, in_ready}, 64'd1);
        chk("valid_after_rst", {63'd0, out_valid}, 64'd0);
    endtask

    // Single beat into an empty pipe: checks constant product, tag and latency.
    task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                            input mul_mode_e mode, input logic [TW-1:0] t, input logic [63:0] expv);
        mul_ctrl_t ctl;
        int        lat;
        ctl       = mode_ctrl(mode);
        lat       = -1;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        a_signed  = ctl.a_signed;
        b_signed  = ctl.b_signed;
        in_tag    = t;
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        in_tag    = ~t;
        for (int i = 1; i <= 10; i++) begin
            if (out_valid && lat < 0) begin
                lat = i;
                chk({name, "_prod"}, product, expv);
                chk({name, "_tag"}, {59'd0, out_tag}, {59'd0, t});
            end
            cycle();
        end
        chk({name, "_latency"}, lat, S);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;

        @(negedge clk);
        reset_now();

        directed("uu_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_HUU, 5'd7, 64'hFFFF_FFFE_0000_0001);
        directed("ss_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_HSS, 5'd1, 64'h0000_0000_0000_0001);
        directed("ss_min",  32'h8000_0000, 32'h8000_0000, MUL_HSS, 5'd3, 64'h4000_0000_0000_0000);
        directed("su_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_HSU, 5'd4, 64'hFFFF_FFFF_0000_0001);

        // Backpressure: ten back-to-back beats, consumer stalls for cycles 4..7.
        idx = 0;
        for (int c = 0; c < 60 && (idx < 10 || sb.size() > 0); c++) begin
            in_valid  = (idx < 10);
            a         = $urandom;
            b         = $urandom;
            a_signed  = 1'($urandom);
            b_signed  = 1'($urandom);
            in_tag    = TW'(idx);
            out_ready = !(c >= 4 && c <= 7);
            if (c >= 4 && c <= 7) begin
                #1;
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            end
            cycle();
            if (acc_flag) idx++;
        end
        chk("bp_accepted", idx, 10);
        chk("bp_drained", sb.size(), 0);

        // Reset with three beats in flight; the oldest is already presented.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            in_tag   = TW'(10 + i);
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        reset_now();
        for (int i = 0; i < 6; i++) cycle();
        directed("post_rst", 32'd5, 32'd7, MUL_HUU, 5'd2, 64'd35);

        // Randomized stream with random bubbles and random backpressure.
        idx = 0;
        for (int c = 0; c < 1000 && idx < 150; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            a_signed  = 1'($urandom);
            b_signed  = 1'($urandom);
            in_tag    = TW'(idx);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc_flag) idx++;
        end
        chk("rand_accepted", idx, 150);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) cycle();
        chk("rand_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
